mul_add: RTL and testbench
==========================

# mul_add

Iterative unsigned multiply-add unit. It computes `product = a*b + c` using one shift-add step per clock, with a start/done handshake. It is the arithmetic inverse of the pipelined divider: given `quotient`, `divisor` and `remainder`, it reconstructs the dividend. The intended uses are as a divider self-check companion and as a small-area multiplier where throughput is not critical.

## Interface
- `N`, default 8: operand width in bits; the result is 2N bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only while idle.
- `a`  in  N  multiplicand (unsigned); captured on an accepted start.
- `b`  in  N  multiplier (unsigned); captured on an accepted start.
- `c`  in  N  addend (unsigned, zero-extended); captured on an accepted start.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `product` has been updated.
- `product`  out  2N  result register; holds its value until the next completion.

## Operation
- FSM states: IDLE and RUN.
- IDLE with `start=1` at edge t:
  - `acc <= {N'b0, c}`, `mcand <= {N'b0, a}`, `mplier <= b`, `cnt <= 0`.
  - Go to RUN; `busy=1` after edge t.
- RUN, each edge:
  - If `mplier[0]`, `acc <= acc + mcand`.
  - `mcand <= mcand << 1`, `mplier <= mplier >> 1`, `cnt <= cnt + 1`.
- Completion in RUN happens when `cnt == N-1` (base build):
  - `product <=` the final acc value, including this step's add.
  - `done <= 1`, `busy <= 0`, state goes to IDLE.
- Width rule: the maximum result is (2^N-1)^2 + (2^N-1) = 2^2N - 2^N. This fits in 2N bits, so no overflow is possible and no carry-out exists.
- `start` in RUN is ignored: no capture, no effect on the current operation.
- `start` in the cycle `done` is high is accepted, because the state is already IDLE. Back-to-back operations are therefore supported.
- `a`, `b`, `c` are don't-care except at the accepting edge.
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE, `busy=0`, `done=0`, `product=0`.
  - acc, mcand, mplier and cnt are all 0.
  - The in-flight operation is discarded and no `done` is produced.

## Timing
- Start accepted at edge t. Iterations occur on edges t+1 … t+N.
- `done`=1 and `product` valid after edge t+N. `done` clears at edge t+N+1 unless another completion occurs.
- `busy` is high from after edge t until after edge t+N.
- Latency: N cycles, start-edge to done. Throughput: one result per N+1 cycles, since the next start is accepted while `done` is high.
- `product` changes only on a completion edge or on reset.

## Configuration
- `MUL_ADD_EARLY_EN` defined: early termination.
  - Completion also occurs on any RUN edge where the shifted multiplier (`mplier >> 1`) is zero.
  - Latency becomes max(1, msb_index(b)+1) cycles. For `b=0`, done comes at t+1 with `product=c`.
  - The result is identical to the base build.
- Undefined: latency is always exactly N cycles, independent of the operands.

## Test plan
- N=8, a=13, b=11, c=7, start at edge t -> `done` after edge t+8, `product`=16'h0096 (150); `busy` high for 8 cycles.
- a=255, b=255, c=255 -> `product`=16'hFF00; no overflow.
- Start a=2, b=3, c=0, then pulse start with a=9, b=9, c=9 at t+3 -> single done at t+8 with `product`=6; the second request is ignored.
- Back-to-back: a second start (a=1, b=1, c=1) asserted in the cycle `done` is high -> second done 8 cycles later with `product`=2; the first result stays visible until then.
- Reset: `rst_n` low at t+4 of an operation -> `busy`, `done` and `product` go to 0 immediately; after release, no done occurs until a new start.
- With `MUL_ADD_EARLY_EN`: a=5, b=3, c=1 -> done at t+2, `product`=16; with b=0, done at t+1, `product`=c. Without the macro, both cases complete at t+8 with the same values.

Source files
------------

// File: rtl/mul_add_if.sv
// ---------------------------------------------------------------------------
// mul_add_if : start/done handshake and operand/result bus for mul_add
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mul_add_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [N-1:0]   c;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, a, b, c,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b, c,
    output busy, done, product
  );
endinterface

`default_nettype wire

// File: rtl/mul_add.sv
// ---------------------------------------------------------------------------
// mul_add  : iterative unsigned a*b+c, one shift-add step per clock
// Option   : MUL_ADD_EARLY_EN finishes as soon as the remaining multiplier is 0
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_add #(
  parameter int N = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  mul_add_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int             CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t         state;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  logic [2*N-1:0] acc_step;
  logic           last_step;

  // Worst case a*b+c = 2^2N - 2^N, so the 2N-bit accumulator never carries out.
  always_comb begin
    acc_step = acc;
    if (mplier[0]) begin
      acc_step = acc + mcand;
    end
  end

`ifdef MUL_ADD_EARLY_EN
  assign last_step = (cnt == LAST) || ((mplier >> 1) == '0);
`else
  assign last_step = (cnt == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= {{N{1'b0}}, bus.c};
            mcand  <= {{N{1'b0}}, bus.a};
            mplier <= bus.b;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            product <= acc_step;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;

endmodule

`default_nettype wire

// File: tb/tb_mul_add.sv
// ---------------------------------------------------------------------------
// tb_mul_add : directed and random checks of mul_add against an a*b+c model
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mul_add;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [2*N-1:0] last_prod;

  mul_add_if #(.N(N)) bif ();

  mul_add #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from accepting edge to done, derived from the operand rather than the RTL state.
  function automatic int latency(input logic [N-1:0] b);
    int msb;
`ifdef MUL_ADD_EARLY_EN
    msb = -1;
    for (int i = 0; i < N; i++) if (b[i]) msb = i;
    return (msb < 0) ? 1 : msb + 1;
`else
    msb = 0;
    return N + msb;
`endif
  endfunction

  // Present a request; returns 1 ns after the edge that samples it.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    bif.start = 1'b1;
    bif.a     = a;
    bif.b     = b;
    bif.c     = c;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.a     = N'($urandom);
    bif.b     = N'($urandom);
    bif.c     = N'($urandom);
  endtask

  // Follow one accepted operation edge by edge; optionally pulse start at cycle pulse_at.
  task automatic follow(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input int pulse_at);
    int unsigned expv;
    int          lat;
    expv = int'(a) * int'(b) + int'(c);
    lat  = latency(b);
    for (int k = 1; k <= lat; k++) begin
      if (k == pulse_at) begin
        bif.start = 1'b1;
        bif.a = 8'd9; bif.b = 8'd9; bif.c = 8'd9;
      end
      @(posedge clk);
      #1;
      bif.start = 1'b0;
      if (k < lat) begin
        check({tag, "_busy"}, 32'(bif.busy), 32'd1);
        check({tag, "_nodone"}, 32'(bif.done), 32'd0);
        check({tag, "_hold"}, 32'(bif.product), 32'(last_prod));
      end else begin
        check({tag, "_done"}, 32'(bif.done), 32'd1);
        check({tag, "_idle"}, 32'(bif.busy), 32'd0);
        check({tag, "_prod"}, 32'(bif.product), expv);
      end
    end
    last_prod = (2*N)'(expv);
  endtask

  task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic [N-1:0] c, input int pulse_at);
    issue(a, b, c);
    follow(tag, a, b, c, pulse_at);
  endtask

  initial begin
    logic [N-1:0] ra, rb, rc;
    checks    = 0;
    errors    = 0;
    last_prod = '0;
    bif.start = 1'b0;
    bif.a = '0; bif.b = '0; bif.c = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_prod", 32'(bif.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op("basic", 8'd13, 8'd11, 8'd7, 0);
    check("basic_val", 32'(bif.product), 32'h0096);
    @(negedge clk);
    op("max", 8'd255, 8'd255, 8'd255, 0);
    check("max_val", 32'(bif.product), 32'hFF00);
    @(negedge clk);
    op("ignore", 8'd2, 8'd3, 8'd0, 3);
    // Second start ignored: no further done and product stays 6.
    repeat (3) begin
      @(posedge clk); #1;
      check("ignore_quiet", 32'(bif.done), 32'd0);
    end
    check("ignore_val", 32'(bif.product), 32'd6);

    // Back-to-back: issue while done is still high.
    op("b2b_a", 8'd20, 8'd200, 8'd3, 0);
    check("b2b_donehigh", 32'(bif.done), 32'd1);
    op("b2b_b", 8'd1, 8'd1, 8'd1, 0);
    check("b2b_val", 32'(bif.product), 32'd2);

    @(negedge clk);
    op("early", 8'd5, 8'd3, 8'd1, 0);
    check("early_val", 32'(bif.product), 32'd16);
    @(negedge clk);
    op("bzero", 8'd77, 8'd0, 8'd42, 0);
    check("bzero_val", 32'(bif.product), 32'd42);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    issue(8'd100, 8'd200, 8'd50);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bif.busy), 32'd0);
    check("mid_rst_done", 32'(bif.done), 32'd0);
    check("mid_rst_prod", 32'(bif.product), 32'd0);
    last_prod = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 3) begin
      @(posedge clk); #1;
      check("post_rst_done", 32'(bif.done), 32'd0);
      check("post_rst_busy", 32'(bif.busy), 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = N'($urandom);
      if (i % 6 == 0) rb = N'($urandom_range(0, 3));
      op("rand", ra, rb, rc, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
